// File: rtl/vending_machine_def_pkg.sv
// Shared definitions for the vending credit logic: FSM state encoding and default
// denomination/price tables and timeout reload value.
package vending_machine_def;

    localparam int unsigned VALUE_W        = 32;
    localparam int unsigned DEF_NUM_COINS  = 3;
    localparam int unsigned DEF_NUM_ITEMS  = 4;
    localparam int unsigned DEF_TOTAL_BITS = 31;
    localparam int unsigned DEF_WAIT_TIME  = 100;
    localparam int unsigned DEF_MAX_CREDIT = 5000;

    // Index 0 sits in the least-significant 32 bits.
    localparam logic [DEF_NUM_COINS*VALUE_W-1:0] DEF_COIN_VALUES =
        {32'd1000, 32'd500, 32'd100};
    localparam logic [DEF_NUM_ITEMS*VALUE_W-1:0] DEF_ITEM_PRICES =
        {32'd2000, 32'd1000, 32'd500, 32'd400};

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_CREDIT = 2'd1,
        ST_RETURN = 2'd2
    } state_t;

endpackage

// File: rtl/change_picker.sv
// change_picker: combinational selection of the largest denomination that still fits
// in the remaining credit; found_c is low when no denomination fits.
module change_picker
    import vending_machine_def::*;
#(
    parameter int unsigned                  NUM_COINS   = DEF_NUM_COINS,
    parameter int unsigned                  TOTAL_BITS  = DEF_TOTAL_BITS,
    parameter logic [NUM_COINS*VALUE_W-1:0] COIN_VALUES = DEF_COIN_VALUES
) (
    input  logic [TOTAL_BITS-1:0] credit,
    output logic [NUM_COINS-1:0]  coin_c,
    output logic [TOTAL_BITS-1:0] value_c,
    output logic                  found_c
);

    localparam int unsigned CMP_W = (TOTAL_BITS > VALUE_W) ? TOTAL_BITS : VALUE_W;

    logic [CMP_W-1:0] best_c;
    logic [CMP_W-1:0] cand_c;

    // Tables need not be sorted, so scan every denomination for the best fit.
    always_comb begin
        coin_c  = '0;
        best_c  = '0;
        cand_c  = '0;
        found_c = 1'b0;
        for (int i = 0; i < int'(NUM_COINS); i++) begin
            cand_c = CMP_W'(COIN_VALUES[i*VALUE_W +: VALUE_W]);
            if ((cand_c != '0) && (cand_c <= CMP_W'(credit)) &&
                (!found_c || (cand_c > best_c))) begin
                coin_c    = '0;
                coin_c[i] = 1'b1;
                best_c    = cand_c;
                found_c   = 1'b1;
            end
        end
    end

    assign value_c = TOTAL_BITS'(best_c);

endmodule

// File: rtl/coin_credit_timer.sv
// coin_credit_timer: vending credit accumulator with idle timeout and coin-by-coin change return.
// Build macro CREDIT_CAP_EN refuses any coin that would lift credit above MAX_CREDIT.
module coin_credit_timer
    import vending_machine_def::*;
#(
    parameter int unsigned                  NUM_COINS   = DEF_NUM_COINS,
    parameter int unsigned                  NUM_ITEMS   = DEF_NUM_ITEMS,
    parameter int unsigned                  TOTAL_BITS  = DEF_TOTAL_BITS,
    parameter int unsigned                  WAIT_TIME   = DEF_WAIT_TIME,
    parameter logic [NUM_COINS*VALUE_W-1:0] COIN_VALUES = DEF_COIN_VALUES,
    parameter logic [NUM_ITEMS*VALUE_W-1:0] ITEM_PRICES = DEF_ITEM_PRICES,
    parameter int unsigned                  MAX_CREDIT  = DEF_MAX_CREDIT
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NUM_COINS-1:0]  i_input_coin,
    input  logic [NUM_ITEMS-1:0]  i_select_item,
    input  logic                  i_trigger_return,
    output logic [NUM_ITEMS-1:0]  o_available_item,
    output logic [NUM_ITEMS-1:0]  o_output_item,
    output logic [NUM_COINS-1:0]  o_return_coin,
    output logic [NUM_COINS-1:0]  o_reject_coin,
    output logic [TOTAL_BITS-1:0] o_credit,
    output logic [31:0]           o_wait_time,
    output logic                  o_busy
);

    localparam int unsigned SUM_W = ((TOTAL_BITS > VALUE_W) ? TOTAL_BITS : VALUE_W) + 1;

    state_t                state_q;
    state_t                state_nxt;

    logic                  coin_ok_c;
    logic                  sel_ok_c;
    logic                  take_coin_c;
    logic                  accept_coin_c;
    logic                  take_sel_c;
    logic                  coin_refused_c;
    logic [VALUE_W-1:0]    coin_val_c;
    logic [VALUE_W-1:0]    price_c;
    logic [SUM_W-1:0]      sum_c;
    logic [TOTAL_BITS-1:0] coin_sum_c;

    logic [NUM_COINS-1:0]  pick_coin_c;
    logic [TOTAL_BITS-1:0] pick_value_c;
    logic                  pick_found_c;

    logic [TOTAL_BITS-1:0] credit_nxt;
    logic [31:0]           wait_nxt;
    logic [NUM_ITEMS-1:0]  avail_nxt;
    logic [NUM_ITEMS-1:0]  item_nxt;
    logic [NUM_COINS-1:0]  ret_nxt;
    logic [NUM_COINS-1:0]  rej_nxt;

    change_picker #(
        .NUM_COINS   (NUM_COINS),
        .TOTAL_BITS  (TOTAL_BITS),
        .COIN_VALUES (COIN_VALUES)
    ) u_change_picker (
        .credit  (o_credit),
        .coin_c  (pick_coin_c),
        .value_c (pick_value_c),
        .found_c (pick_found_c)
    );

    // Value lookup for the one-hot coin and item inputs.
    always_comb begin
        coin_val_c = '0;
        price_c    = '0;
        for (int i = 0; i < int'(NUM_COINS); i++) begin
            if (i_input_coin[i]) coin_val_c |= COIN_VALUES[i*VALUE_W +: VALUE_W];
        end
        for (int i = 0; i < int'(NUM_ITEMS); i++) begin
            if (i_select_item[i]) price_c |= ITEM_PRICES[i*VALUE_W +: VALUE_W];
        end
    end

    assign coin_ok_c     = $onehot(i_input_coin);
    assign sel_ok_c      = $onehot(i_select_item);
    assign sum_c         = SUM_W'(o_credit) + SUM_W'(coin_val_c);
    assign coin_sum_c    = (sum_c > SUM_W'({TOTAL_BITS{1'b1}})) ? '1 : TOTAL_BITS'(sum_c);
    assign take_coin_c   = coin_ok_c && !i_trigger_return;
    assign accept_coin_c = take_coin_c && !coin_refused_c;
    // o_available_item is already gated by the CREDIT state and current credit.
    assign take_sel_c    = !i_trigger_return && !coin_ok_c && sel_ok_c &&
                           (|(i_select_item & o_available_item));

`ifdef CREDIT_CAP_EN
    assign coin_refused_c = sum_c > SUM_W'(MAX_CREDIT);
`else
    logic unused_max_credit;
    assign coin_refused_c    = 1'b0;
    assign unused_max_credit = ^MAX_CREDIT;
`endif

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= ST_IDLE;
        else       state_q <= state_nxt;
    end

    // Next-state decode.
    always_comb begin
        state_nxt = state_q;
        case (state_q)
            ST_IDLE: begin
                if (accept_coin_c) state_nxt = ST_CREDIT;
            end
            ST_CREDIT: begin
                if (i_trigger_return)                  state_nxt = ST_RETURN;
                else if (accept_coin_c || take_sel_c) state_nxt = ST_CREDIT;
                else if (o_wait_time == 32'd0)         state_nxt = ST_RETURN;
            end
            ST_RETURN: begin
                if (!pick_found_c) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Next values for the registered outputs.
    always_comb begin
        credit_nxt = o_credit;
        wait_nxt   = o_wait_time;
        avail_nxt  = '0;
        item_nxt   = '0;
        ret_nxt    = '0;
        rej_nxt    = '0;
        case (state_q)
            ST_IDLE: begin
                wait_nxt = '0;
                if (accept_coin_c) begin
                    credit_nxt = coin_sum_c;
                    wait_nxt   = 32'(WAIT_TIME);
                end else if (take_coin_c) begin
                    rej_nxt = i_input_coin;
                end
            end
            ST_CREDIT: begin
                if (i_trigger_return) begin
                    wait_nxt = '0;
                end else if (accept_coin_c) begin
                    credit_nxt = coin_sum_c;
                    wait_nxt   = 32'(WAIT_TIME);
                end else if (take_sel_c) begin
                    credit_nxt = o_credit - TOTAL_BITS'(price_c);
                    item_nxt   = i_select_item;
                    wait_nxt   = 32'(WAIT_TIME);
                end else begin
                    if (take_coin_c) rej_nxt = i_input_coin;
                    if (o_wait_time != 32'd0) wait_nxt = o_wait_time - 32'd1;
                end
            end
            ST_RETURN: begin
                wait_nxt = '0;
                if (coin_ok_c) rej_nxt = i_input_coin;
                if (pick_found_c) begin
                    ret_nxt    = pick_coin_c;
                    credit_nxt = o_credit - pick_value_c;
                end else begin
                    credit_nxt = '0;
                end
            end
            default: begin
                credit_nxt = '0;
                wait_nxt   = '0;
            end
        endcase
        for (int i = 0; i < int'(NUM_ITEMS); i++) begin
            avail_nxt[i] = (state_nxt == ST_CREDIT) &&
                           (SUM_W'(credit_nxt) >= SUM_W'(ITEM_PRICES[i*VALUE_W +: VALUE_W]));
        end
    end

    // Output registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            o_credit         <= '0;
            o_wait_time      <= '0;
            o_available_item <= '0;
            o_output_item    <= '0;
            o_return_coin    <= '0;
            o_reject_coin    <= '0;
            o_busy           <= 1'b0;
        end else begin
            o_credit         <= credit_nxt;
            o_wait_time      <= wait_nxt;
            o_available_item <= avail_nxt;
            o_output_item    <= item_nxt;
            o_return_coin    <= ret_nxt;
            o_reject_coin    <= rej_nxt;
            o_busy           <= (state_nxt == ST_RETURN);
        end
    end

endmodule

// File: tb/tb_coin_credit_timer.sv
// Bench for coin_credit_timer: directed vector table, corner-case sequences and
// randomized traffic checked against a rule-level reference model.
module tb_coin_credit_timer;

    localparam int  WAIT  = 100;
    localparam int  CAP   = 5000;
    localparam int  S_IDLE   = 0;
    localparam int  S_CREDIT = 1;
    localparam int  S_RETURN = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic [2:0]  i_input_coin;
    logic [3:0]  i_select_item;
    logic        i_trigger_return;
    logic [3:0]  o_available_item;
    logic [3:0]  o_output_item;
    logic [2:0]  o_return_coin;
    logic [2:0]  o_reject_coin;
    logic [30:0] o_credit;
    logic [31:0] o_wait_time;
    logic        o_busy;

    coin_credit_timer dut (
        .clk              (clk),
        .reset            (reset),
        .i_input_coin     (i_input_coin),
        .i_select_item    (i_select_item),
        .i_trigger_return (i_trigger_return),
        .o_available_item (o_available_item),
        .o_output_item    (o_output_item),
        .o_return_coin    (o_return_coin),
        .o_reject_coin    (o_reject_coin),
        .o_credit         (o_credit),
        .o_wait_time      (o_wait_time),
        .o_busy           (o_busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    int coin_val[3]   = '{100, 500, 1000};
    int item_price[4] = '{400, 500, 1000, 2000};

    // Reference model state.
    int         m_state;
    longint     m_credit;
    int         m_wait;
    logic [3:0] e_item;
    logic [2:0] e_ret;
    logic [2:0] e_rej;

    typedef struct {
        logic [2:0] coin;
        logic [3:0] sel;
        logic       ret;
        int         credit;
        logic [3:0] avail;
        logic [3:0] item;
        logic [2:0] rc;
        logic [2:0] rej;
        int         wt;
        logic       busy;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int onehot_idx(input logic [7:0] v);
        int idx;
        idx = -1;
        if ($countones(v) == 1) begin
            for (int k = 0; k < 8; k++) if (v[k]) idx = k;
        end
        return idx;
    endfunction

    function automatic longint sat(input longint v);
        longint top;
        top = (longint'(1) << 31) - 1;
        return (v > top) ? top : v;
    endfunction

    function automatic logic [3:0] model_avail();
        logic [3:0] a;
        a = '0;
        for (int k = 0; k < 4; k++) a[k] = (m_state == S_CREDIT) && (m_credit >= item_price[k]);
        return a;
    endfunction

    task automatic model_reset();
        m_state  = S_IDLE;
        m_credit = 0;
        m_wait   = 0;
        e_item   = '0;
        e_ret    = '0;
        e_rej    = '0;
    endtask

    // One clock of the vending rules applied to the model.
    task automatic model_step(input logic [2:0] coin, input logic [3:0] sel, input logic ret);
        int ci;
        int si;
        int best;
        bit refuse;
        ci = onehot_idx(8'(coin));
        si = onehot_idx(8'(sel));
        e_item = '0;
        e_ret  = '0;
        e_rej  = '0;
        refuse = 1'b0;
`ifdef CREDIT_CAP_EN
        if (ci >= 0) refuse = (m_credit + coin_val[ci]) > CAP;
`endif
        case (m_state)
            S_IDLE: begin
                if (!ret && ci >= 0) begin
                    if (refuse) e_rej = coin;
                    else begin
                        m_credit = sat(m_credit + coin_val[ci]);
                        m_wait   = WAIT;
                        m_state  = S_CREDIT;
                    end
                end
            end
            S_CREDIT: begin
                if (ret) begin
                    m_state = S_RETURN;
                    m_wait  = 0;
                end else if (ci >= 0 && !refuse) begin
                    m_credit = sat(m_credit + coin_val[ci]);
                    m_wait   = WAIT;
                end else if (ci < 0 && si >= 0 && m_credit >= item_price[si]) begin
                    m_credit = m_credit - item_price[si];
                    e_item   = sel;
                    m_wait   = WAIT;
                end else begin
                    if (ci >= 0) e_rej = coin;
                    if (m_wait == 0) m_state = S_RETURN;
                    else m_wait = m_wait - 1;
                end
            end
            default: begin
                if (ci >= 0) e_rej = coin;
                m_wait = 0;
                best = -1;
                for (int k = 0; k < 3; k++) begin
                    if (coin_val[k] <= m_credit && (best < 0 || coin_val[k] > coin_val[best])) best = k;
                end
                if (best >= 0) begin
                    e_ret    = 3'(1 << best);
                    m_credit = m_credit - coin_val[best];
                end else begin
                    m_credit = 0;
                    m_state  = S_IDLE;
                end
            end
        endcase
    endtask

    task automatic step(input logic [2:0] c, input logic [3:0] s, input logic r);
        i_input_coin     = c;
        i_select_item    = s;
        i_trigger_return = r;
        @(posedge clk);
        #1;
        i_input_coin     = '0;
        i_select_item    = '0;
        i_trigger_return = 1'b0;
        model_step(c, s, r);
    endtask

    task automatic compare_all(input string tag);
        check({tag, ".credit"}, longint'(o_credit), m_credit);
        check({tag, ".wait"},   longint'(o_wait_time), longint'(m_wait));
        check({tag, ".avail"},  longint'(o_available_item), longint'(model_avail()));
        check({tag, ".item"},   longint'(o_output_item), longint'(e_item));
        check({tag, ".ret"},    longint'(o_return_coin), longint'(e_ret));
        check({tag, ".rej"},    longint'(o_reject_coin), longint'(e_rej));
        check({tag, ".busy"},   longint'(o_busy), (m_state == S_RETURN) ? 1 : 0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, ".credit"}, longint'(o_credit), 0);
        check({tag, ".wait"},   longint'(o_wait_time), 0);
        check({tag, ".avail"},  longint'(o_available_item), 0);
        check({tag, ".item"},   longint'(o_output_item), 0);
        check({tag, ".ret"},    longint'(o_return_coin), 0);
        check({tag, ".rej"},    longint'(o_reject_coin), 0);
        check({tag, ".busy"},   longint'(o_busy), 0);
    endtask

    task automatic do_reset();
        i_input_coin     = '0;
        i_select_item    = '0;
        i_trigger_return = 1'b0;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        model_reset();
    endtask

    task automatic add_vec(input logic [2:0] c, input logic [3:0] s, input logic r,
                           input int cr, input logic [3:0] av, input logic [3:0] it,
                           input logic [2:0] rc, input logic [2:0] rj, input int wt,
                           input logic bz);
        vec_t v;
        v.coin = c;  v.sel = s;  v.ret = r;
        v.credit = cr; v.avail = av; v.item = it; v.rc = rc; v.rej = rj; v.wt = wt; v.busy = bz;
        vecs.push_back(v);
    endtask

    logic [2:0] rc;
    logic [3:0] rs;
    logic       rr;
    int         q;
    bit         quiet;

    initial begin
        //       coin    sel      ret   credit avail    item     rc      rej     wait busy
        add_vec(3'b100, 4'b0000, 1'b0, 1000, 4'b0111, 4'b0000, 3'b000, 3'b000, 100, 1'b0);
        add_vec(3'b010, 4'b0000, 1'b0, 1500, 4'b0111, 4'b0000, 3'b000, 3'b000, 100, 1'b0);
        add_vec(3'b000, 4'b0100, 1'b0,  500, 4'b0011, 4'b0100, 3'b000, 3'b000, 100, 1'b0);
        add_vec(3'b000, 4'b0000, 1'b0,  500, 4'b0011, 4'b0000, 3'b000, 3'b000,  99, 1'b0);
        add_vec(3'b001, 4'b0000, 1'b0,  600, 4'b0011, 4'b0000, 3'b000, 3'b000, 100, 1'b0);
        add_vec(3'b100, 4'b0000, 1'b0, 1600, 4'b0111, 4'b0000, 3'b000, 3'b000, 100, 1'b0);
        add_vec(3'b000, 4'b0000, 1'b1, 1600, 4'b0000, 4'b0000, 3'b000, 3'b000,   0, 1'b1);
        add_vec(3'b000, 4'b0000, 1'b0,  600, 4'b0000, 4'b0000, 3'b100, 3'b000,   0, 1'b1);
        add_vec(3'b000, 4'b0000, 1'b0,  100, 4'b0000, 4'b0000, 3'b010, 3'b000,   0, 1'b1);
        add_vec(3'b000, 4'b0000, 1'b0,    0, 4'b0000, 4'b0000, 3'b001, 3'b000,   0, 1'b1);
        add_vec(3'b000, 4'b0000, 1'b0,    0, 4'b0000, 4'b0000, 3'b000, 3'b000,   0, 1'b0);
        add_vec(3'b001, 4'b0001, 1'b0,  100, 4'b0000, 4'b0000, 3'b000, 3'b000, 100, 1'b0);
        add_vec(3'b100, 4'b0001, 1'b0, 1100, 4'b0111, 4'b0000, 3'b000, 3'b000, 100, 1'b0);
        add_vec(3'b001, 4'b0001, 1'b0, 1200, 4'b0111, 4'b0000, 3'b000, 3'b000, 100, 1'b0);
        add_vec(3'b001, 4'b0000, 1'b1, 1200, 4'b0000, 4'b0000, 3'b000, 3'b000,   0, 1'b1);
        add_vec(3'b010, 4'b0000, 1'b0,  200, 4'b0000, 4'b0000, 3'b100, 3'b010,   0, 1'b1);
        add_vec(3'b000, 4'b0000, 1'b0,  100, 4'b0000, 4'b0000, 3'b001, 3'b000,   0, 1'b1);
        add_vec(3'b000, 4'b0000, 1'b0,    0, 4'b0000, 4'b0000, 3'b001, 3'b000,   0, 1'b1);
        add_vec(3'b000, 4'b0000, 1'b0,    0, 4'b0000, 4'b0000, 3'b000, 3'b000,   0, 1'b0);
        add_vec(3'b000, 4'b0000, 1'b1,    0, 4'b0000, 4'b0000, 3'b000, 3'b000,   0, 1'b0);
        add_vec(3'b011, 4'b0000, 1'b0,    0, 4'b0000, 4'b0000, 3'b000, 3'b000,   0, 1'b0);
        add_vec(3'b001, 4'b0000, 1'b0,  100, 4'b0000, 4'b0000, 3'b000, 3'b000, 100, 1'b0);
        add_vec(3'b000, 4'b1000, 1'b0,  100, 4'b0000, 4'b0000, 3'b000, 3'b000,  99, 1'b0);
        add_vec(3'b000, 4'b0011, 1'b0,  100, 4'b0000, 4'b0000, 3'b000, 3'b000,  98, 1'b0);

        do_reset();
        check_all_zero("reset");

        foreach (vecs[n]) begin
            step(vecs[n].coin, vecs[n].sel, vecs[n].ret);
            check($sformatf("vec%0d.credit", n), longint'(o_credit), longint'(vecs[n].credit));
            check($sformatf("vec%0d.avail", n), longint'(o_available_item), longint'(vecs[n].avail));
            check($sformatf("vec%0d.item", n), longint'(o_output_item), longint'(vecs[n].item));
            check($sformatf("vec%0d.ret", n), longint'(o_return_coin), longint'(vecs[n].rc));
            check($sformatf("vec%0d.rej", n), longint'(o_reject_coin), longint'(vecs[n].rej));
            check($sformatf("vec%0d.wait", n), longint'(o_wait_time), longint'(vecs[n].wt));
            check($sformatf("vec%0d.busy", n), longint'(o_busy), longint'(vecs[n].busy));
        end

        // Idle timeout: wait counts down to 0, then RETURN, then change, then IDLE.
        do_reset();
        step(3'b001, 4'b0000, 1'b0);
        check("tmo.reload", longint'(o_wait_time), WAIT);
        for (int n = 0; n < WAIT; n++) begin
            step(3'b000, 4'b0000, 1'b0);
            compare_all("tmo");
        end
        check("tmo.zero", longint'(o_wait_time), 0);
        check("tmo.busy_pre", longint'(o_busy), 0);
        step(3'b000, 4'b0000, 1'b0);
        check("tmo.busy", longint'(o_busy), 1);
        check("tmo.ret_none", longint'(o_return_coin), 0);
        step(3'b000, 4'b0000, 1'b0);
        check("tmo.ret", longint'(o_return_coin), 3'b001);
        step(3'b000, 4'b0000, 1'b0);
        check("tmo.idle_busy", longint'(o_busy), 0);
        check("tmo.idle_credit", longint'(o_credit), 0);

        // Asynchronous reset in the middle of a change return.
        step(3'b100, 4'b0000, 1'b0);
        step(3'b010, 4'b0000, 1'b0);
        step(3'b000, 4'b0000, 1'b1);
        step(3'b000, 4'b0000, 1'b0);
        check("mid.ret", longint'(o_return_coin), 3'b100);
        check("mid.credit", longint'(o_credit), 500);
        #2;
        reset = 1'b1;
        #1;
        check_all_zero("async_rst");
        @(posedge clk);
        #1;
        reset = 1'b0;
        model_reset();
        step(3'b000, 4'b0000, 1'b0);
        compare_all("post_rst");

        // Credit ceiling behaviour at 4500 + 1000.
        do_reset();
        for (int n = 0; n < 4; n++) step(3'b100, 4'b0000, 1'b0);
        step(3'b010, 4'b0000, 1'b0);
        check("cap.pre", longint'(o_credit), 4500);
        step(3'b100, 4'b0000, 1'b0);
`ifdef CREDIT_CAP_EN
        check("cap.rej", longint'(o_reject_coin), 3'b100);
        check("cap.credit", longint'(o_credit), 4500);
`else
        check("nocap.rej", longint'(o_reject_coin), 0);
        check("nocap.credit", longint'(o_credit), 5500);
`endif
        compare_all("cap");

        // Randomized traffic with periodic quiet windows long enough to time out.
        do_reset();
        for (int n = 0; n < 4000; n++) begin
            quiet = ((n / 250) % 3) == 2;
            rc = '0;
            rs = '0;
            rr = 1'b0;
            if (!quiet) begin
                q = int'($urandom_range(0, 99));
                if (q < 25)      rc = 3'(1 << $urandom_range(0, 2));
                else if (q < 28) rc = 3'($urandom_range(0, 7));
                q = int'($urandom_range(0, 99));
                if (q < 30)      rs = 4'(1 << $urandom_range(0, 3));
                else if (q < 33) rs = 4'($urandom_range(0, 15));
                rr = ($urandom_range(0, 99) < 3);
            end
            step(rc, rs, rr);
            compare_all("rnd");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
